// File: rtl/power_telemetry_uart_if.sv
// Sample input and UART telemetry output bundle for power_telemetry_uart.
// sample_valid is a pure strobe: volt/curr are consumed on every rising edge it is high; there is no ready.
interface power_telemetry_uart_if;
  logic       sample_valid;
  logic [7:0] volt;
  logic [7:0] curr;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic       overrun;
  logic [1:0] dbg_state;

  modport slave (
    input  sample_valid, volt, curr,
    output tx, busy, frame_done, overrun, dbg_state
  );

  modport master (
    output sample_valid, volt, curr,
    input  tx, busy, frame_done, overrun, dbg_state
  );
endinterface

// File: rtl/power_telemetry_uart.sv
// Windowed volt/curr/power averager that ships each window as a 6-byte 8N1 UART frame.
// Frame: A5, avg_v, avg_i, avg_p[15:8], avg_p[7:0], checksum (byte sum mod 256).
module power_telemetry_uart #(
  parameter int CLKS_PER_BIT = 10,
  parameter int LOG2_SAMPLES = 4
) (
  input logic clk,
  input logic rst,
  power_telemetry_uart_if.slave io_tlm
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int SV_W  = 8 + LOG2_SAMPLES;
  localparam int SP_W  = 16 + LOG2_SAMPLES;

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  state_t                  r_state, w_state_next;
  logic [LOG2_SAMPLES-1:0] r_smp_cnt;
  logic [SV_W-1:0]         r_sum_v, r_sum_i, w_sum_v, w_sum_i;
  logic [SP_W-1:0]         r_sum_p, w_sum_p;
  logic [15:0]             w_prod;
  logic                    w_win_close, w_launch;
  logic [7:0]              w_avg_v, w_avg_i, w_chk;
  logic [15:0]             w_avg_p;
  logic [7:0]              r_avg_v, r_avg_i, r_chk;
  logic [15:0]             r_avg_p;
  logic [CNT_W-1:0]        r_clk_cnt;
  logic [2:0]              r_bit_idx, r_byte_idx;
  logic                    w_bit_end, w_last_byte;
  logic                    r_frame_done, r_overrun;
  logic [7:0]              w_byte;
  logic                    w_tx;

  // Window sums include the sample accepted this cycle so the closing edge sees the full window.
  assign w_prod      = io_tlm.volt * io_tlm.curr;
  assign w_sum_v     = r_sum_v + SV_W'(io_tlm.volt);
  assign w_sum_i     = r_sum_i + SV_W'(io_tlm.curr);
  assign w_sum_p     = r_sum_p + SP_W'(w_prod);
  assign w_win_close = io_tlm.sample_valid && (r_smp_cnt == {LOG2_SAMPLES{1'b1}});
  assign w_launch    = w_win_close && (r_state == IDLE);
  assign w_avg_v     = w_sum_v[SV_W-1:LOG2_SAMPLES];
  assign w_avg_i     = w_sum_i[SV_W-1:LOG2_SAMPLES];
  assign w_avg_p     = w_sum_p[SP_W-1:LOG2_SAMPLES];
  assign w_chk       = 8'hA5 + w_avg_v + w_avg_i + w_avg_p[15:8] + w_avg_p[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_smp_cnt <= '0;
      r_sum_v   <= '0;
      r_sum_i   <= '0;
      r_sum_p   <= '0;
      r_avg_v   <= '0;
      r_avg_i   <= '0;
      r_avg_p   <= '0;
      r_chk     <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (io_tlm.sample_valid) begin
        if (w_win_close) begin
          r_smp_cnt <= '0;
          r_sum_v   <= '0;
          r_sum_i   <= '0;
          r_sum_p   <= '0;
        end else begin
          r_smp_cnt <= r_smp_cnt + 1'b1;
          r_sum_v   <= w_sum_v;
          r_sum_i   <= w_sum_i;
          r_sum_p   <= w_sum_p;
        end
      end
      if (w_launch) begin
        r_avg_v <= w_avg_v;
        r_avg_i <= w_avg_i;
        r_avg_p <= w_avg_p;
        r_chk   <= w_chk;
      end
      if (w_win_close && (r_state != IDLE)) r_overrun <= 1'b1;
    end
  end

  assign w_bit_end   = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_last_byte = (r_byte_idx == 3'd5);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (w_launch) w_state_next = START;
      START: if (w_bit_end) w_state_next = DATA;
      DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_state_next = STOP;
      STOP:  if (w_bit_end) w_state_next = w_last_byte ? IDLE : START;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_byte_idx   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_frame_done <= (r_state == STOP) && w_bit_end && w_last_byte;
      if (r_state == IDLE) begin
        r_clk_cnt  <= '0;
        r_bit_idx  <= '0;
        r_byte_idx <= '0;
      end else begin
        r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + CNT_W'(1);
        if (w_bit_end && (r_state == DATA)) r_bit_idx <= r_bit_idx + 3'd1;
        if (w_bit_end && (r_state == STOP)) r_byte_idx <= r_byte_idx + 3'd1;
      end
    end
  end

  always_comb begin
    w_byte = r_chk;
    case (r_byte_idx)
      3'd0:    w_byte = 8'hA5;
      3'd1:    w_byte = r_avg_v;
      3'd2:    w_byte = r_avg_i;
      3'd3:    w_byte = r_avg_p[15:8];
      3'd4:    w_byte = r_avg_p[7:0];
      default: w_byte = r_chk;
    endcase
  end

  always_comb begin
    w_tx = 1'b1;
    case (r_state)
      START:   w_tx = 1'b0;
      DATA:    w_tx = w_byte[r_bit_idx];
      default: w_tx = 1'b1;
    endcase
  end

  assign io_tlm.tx         = w_tx;
  assign io_tlm.busy       = (r_state != IDLE);
  assign io_tlm.frame_done = r_frame_done;
  assign io_tlm.overrun    = r_overrun;
  assign io_tlm.dbg_state  = r_state;

endmodule

// File: tb/tb_power_telemetry_uart.sv
// Directed bench for power_telemetry_uart: decodes each UART frame mid-bit and checks bytes, timing and flags.
module tb_power_telemetry_uart;

  localparam int CPB = 10;
  localparam int FRAME_CYC = 60 * CPB;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  logic [7:0] rx_bytes [6];
  int         rx_busy;
  int         rx_ferr;
  int         rx_fd;
  int         n_wait;
  int         fd_seen;

  power_telemetry_uart_if bus();

  power_telemetry_uart #(
    .CLKS_PER_BIT(CPB),
    .LOG2_SAMPLES(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_tlm (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_samples(input int n, input logic [7:0] v, input logic [7:0] c);
    repeat (n) begin
      @(negedge clk);
      bus.sample_valid = 1'b1;
      bus.volt         = v;
      bus.curr         = c;
    end
  endtask

  task automatic stop_samples();
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic check_start(input string tag);
    check({tag, "_start_busy"}, {31'd0, bus.busy}, 32'd1);
    check({tag, "_start_tx"}, {31'd0, bus.tx}, 32'd0);
    check({tag, "_start_state"}, {30'd0, bus.dbg_state}, 32'd1);
  endtask

  // Called on the negedge of the first start-bit cycle; returns on the first cycle after the frame.
  task automatic capture_frame();
    rx_busy = 0;
    rx_ferr = 0;
    rx_fd   = 0;
    for (int b = 0; b < 6; b++) rx_bytes[b] = 8'h00;
    for (int t = 0; t < FRAME_CYC; t++) begin
      if (bus.busy === 1'b1) rx_busy++;
      if (bus.frame_done === 1'b1) rx_fd++;
      if ((t % CPB) == CPB / 2) begin
        int k;
        int b;
        k = (t / CPB) % 10;
        b = t / (10 * CPB);
        if (k == 0) begin
          if (bus.tx !== 1'b0) rx_ferr++;
        end else if (k == 9) begin
          if (bus.tx !== 1'b1) rx_ferr++;
        end else begin
          rx_bytes[b][k-1] = bus.tx;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4,
                             input logic [7:0] e5);
    capture_frame();
    check({tag, "_b0"}, {24'd0, rx_bytes[0]}, {24'd0, e0});
    check({tag, "_b1"}, {24'd0, rx_bytes[1]}, {24'd0, e1});
    check({tag, "_b2"}, {24'd0, rx_bytes[2]}, {24'd0, e2});
    check({tag, "_b3"}, {24'd0, rx_bytes[3]}, {24'd0, e3});
    check({tag, "_b4"}, {24'd0, rx_bytes[4]}, {24'd0, e4});
    check({tag, "_b5"}, {24'd0, rx_bytes[5]}, {24'd0, e5});
    check({tag, "_busy_cycles"}, rx_busy, FRAME_CYC);
    check({tag, "_framing_errs"}, rx_ferr, 32'd0);
    check({tag, "_early_done"}, rx_fd, 32'd0);
    check({tag, "_end_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_end_done"}, {31'd0, bus.frame_done}, 32'd1);
    check({tag, "_end_tx"}, {31'd0, bus.tx}, 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, bus.frame_done}, 32'd0);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    // Reset with sample_valid high: those samples must not enter the window.
    rst              = 1'b1;
    bus.sample_valid = 1'b1;
    bus.volt         = 8'd150;
    bus.curr         = 8'd85;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, bus.tx}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.frame_done}, 32'd0);
    check("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    check("rst_state", {30'd0, bus.dbg_state}, 32'd0);
    rst              = 1'b0;
    bus.sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    // 16 x 150/85: avg 96/55, power 12750 = 0x31CE, checksum 8F.
    send_samples(16, 8'd150, 8'd85);
    stop_samples();
    check_start("f1");
    check_frame("f1", 8'hA5, 8'h96, 8'h55, 8'h31, 8'hCE, 8'h8F);
    check("f1_overrun", {31'd0, bus.overrun}, 32'd0);

    // Half zero, half full scale: truncating averages 7F/7F/7F00, checksum 22.
    repeat (4) @(negedge clk);
    send_samples(8, 8'd0, 8'd0);
    send_samples(8, 8'd255, 8'd255);
    stop_samples();
    check_start("f2");
    check_frame("f2", 8'hA5, 8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h22);

    // Gapped valid: frame starts the cycle after the 16th accepted sample.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.sample_valid = 1'b1;
      bus.volt         = 8'd150;
      bus.curr         = 8'd85;
      @(negedge clk);
      bus.sample_valid = 1'b0;
    end
    check_start("f3");
    check_frame("f3", 8'hA5, 8'h96, 8'h55, 8'h31, 8'hCE, 8'h8F);
    check("f3_overrun", {31'd0, bus.overrun}, 32'd0);

    // Continuous valid: window 2 lands mid-frame (overrun); next frame waits for window boundary at 608.
    repeat (3) @(negedge clk);
    send_samples(16, 8'd150, 8'd85);
    @(negedge clk);
    check_start("f4");
    check("f4_overrun_before", {31'd0, bus.overrun}, 32'd0);
    check_frame("f4", 8'hA5, 8'h96, 8'h55, 8'h31, 8'hCE, 8'h8F);
    check("f4_overrun_after", {31'd0, bus.overrun}, 32'd1);
    n_wait = 0;
    while ((bus.busy !== 1'b1) && (n_wait < 40)) begin
      @(negedge clk);
      n_wait++;
    end
    check("f5_gap_cycles", n_wait, 32'd7);
    check_start("f5");

    // Reset in the middle of byte 3 of the in-flight frame.
    repeat (335) @(negedge clk);
    check("f5_midframe_state", {30'd0, bus.dbg_state}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", {31'd0, bus.tx}, 32'd1);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_overrun", {31'd0, bus.overrun}, 32'd0);
    check("abort_done", {31'd0, bus.frame_done}, 32'd0);
    @(negedge clk);
    rst              = 1'b0;
    bus.sample_valid = 1'b0;
    fd_seen          = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ((bus.frame_done === 1'b1) || (bus.busy === 1'b1)) fd_seen++;
    end
    check("abort_quiet", fd_seen, 32'd0);

    // 16 x 200/10: avg C8/0A, power 2000 = 0x07D0, checksum 4E.
    send_samples(15, 8'd200, 8'd10);
    stop_samples();
    check("f6_no_early_start", {31'd0, bus.busy}, 32'd0);
    send_samples(1, 8'd200, 8'd10);
    stop_samples();
    check_start("f6");
    check_frame("f6", 8'hA5, 8'hC8, 8'h0A, 8'h07, 8'hD0, 8'h4E);
    check("f6_overrun", {31'd0, bus.overrun}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/power_telemetry_uart.md
POWER_TELEMETRY_UART -- requirements
Module: power_telemetry_uart

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10, meaning clk cycles per UART bit (integer >= 2).
REQ-002 SHALL have parameter LOG2_SAMPLES, default 4, meaning window length of 2^LOG2_SAMPLES accepted samples (range 1..8).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sample_valid  input  1  volt/curr valid this cycle; no backpressure.
REQ-006 SHALL have port volt  input  8  unsigned converter voltage sample.
REQ-007 SHALL have port curr  input  8  unsigned converter current sample.
REQ-008 SHALL have port tx  output  1  UART 8N1 serial telemetry out, idle high.
REQ-009 SHALL have port busy  output  1  high while a frame is being shifted out.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse after the last stop bit of a frame.
REQ-011 SHALL have port overrun  output  1  sticky flag: a completed window was dropped.

Function
REQ-012 SHALL accept a sample on every cycle with sample_valid=1 and ignore volt/curr otherwise.
REQ-013 SHALL accumulate per window: sum_v, sum_i (8+LOG2_SAMPLES bits) and sum_p of volt*curr (16+LOG2_SAMPLES bits), no saturation or overflow possible.
REQ-014 SHALL close a window on the edge accepting the 2^LOG2_SAMPLES-th sample, computing avg_v=sum_v>>LOG2_SAMPLES, avg_i=sum_i>>LOG2_SAMPLES, avg_p=sum_p>>LOG2_SAMPLES (16 bits), truncating.
REQ-015 SHALL clear accumulators and sample counter at window close; the next accepted sample starts the next window.
REQ-016 SHALL, if not busy at window close, latch the frame and start transmission: busy and tx low (start bit) from the following cycle.
REQ-017 SHALL, if busy at window close, discard that window's results, set overrun, leave the in-flight frame unaffected.
REQ-018 SHALL keep accumulating samples during transmission regardless of busy.
REQ-019 SHALL send 6 bytes in order: 0xA5, avg_v, avg_i, avg_p[15:8], avg_p[7:0], checksum = sum of previous 5 bytes mod 256.
REQ-020 SHALL send each byte as start bit 0, 8 data bits LSB first, stop bit 1, each exactly CLKS_PER_BIT cycles; bytes back-to-back with no idle gap.
REQ-021 SHALL use FSM states IDLE, START, DATA, STOP; IDLE->START on accepted window; START->DATA after 1 bit; DATA->STOP after 8 bits; STOP->START if bytes remain else ->IDLE.
REQ-022 SHALL hold busy high for exactly 60*CLKS_PER_BIT cycles per frame, and pulse frame_done on the first cycle busy is low after.
REQ-023 SHALL, when a window closes on the same cycle frame_done pulses, treat the block as not busy and start the new frame the next cycle (no overrun).
REQ-024 SHALL clear overrun only by rst.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, set tx=1, busy=0, frame_done=0, overrun=0, FSM=IDLE, counters and accumulators=0.
REQ-026 SHALL abort any in-flight frame on reset (tx high next cycle, no frame_done) and discard the partial window.
REQ-027 SHALL ignore sample_valid during cycles with rst=1.

Verification
REQ-028 SHALL pass: 16 samples volt=150, curr=85 -> bytes A5,96,55,31,CE,8F on tx; busy 600 cycles; one frame_done.
REQ-029 SHALL pass: 8 samples 0/0 then 8 samples 255/255 -> bytes A5,7F,7F,7F,00,22.
REQ-030 SHALL pass: sample_valid toggling every other cycle, 16 valid samples of 150/85 -> same frame as REQ-028, start bit one cycle after 16th valid sample.
REQ-031 SHALL pass: sample_valid held high continuously -> first frame from window 1, overrun=1 after window 2 closes, frames only back-to-back at window boundaries after frame_done.
REQ-032 SHALL pass: rst asserted during byte 3 of a frame -> tx=1, busy=0, overrun=0 next cycle; following 16 samples produce a complete correct frame.
